// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Pipeline stage register with a valid/ready handshake and a one-entry skid
//   buffer. It runs at full throughput, and in_ready comes from a flop rather
//   than from out_ready. A synchronous flush empties the stage and drives the
//   bubble payload FLUSH_DATA. A saturating counter records stalled cycles.
//
// Parameters
//   WIDTH      payload width in bits (>= 1)
//   FLUSH_DATA payload presented after reset or flush (default: pc=0, NOP)
//   CNT_W      stall counter width (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   flush      squash every held entry; drops a payload offered this cycle
//   in_valid   upstream payload valid
//   in_ready   stage can accept (registered)
//   in_data    upstream payload
//   out_valid  out_data holds a live payload (registered)
//   out_ready  downstream accepts this cycle
//   out_data   payload to the next stage (registered)
//   occupancy  number of held entries: 0, 1 or 2
//   stall_cnt  cycles with out_valid=1 and out_ready=0, saturating
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned      WIDTH      = 64,
  parameter logic [WIDTH-1:0] FLUSH_DATA = WIDTH'(64'h0000_0000_0000_0013),
  parameter int unsigned      CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // The state value is the occupancy. ST_FULL also serves as the valid bit
  // of the skid register, and out_valid_q is the valid bit of the main register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic in_fire;
  logic out_fire;

  // The handshake terms use only registered state plus the incoming strobes.
  // The outputs are flops, so none of them depends combinationally on an input.
  assign in_fire  = in_valid & in_ready_q & ~flush;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          // Downstream is stalled. Park the newer entry and keep main as the older one.
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush overrides every transition. A concurrent out_fire has already
    // completed downstream, and an offered payload is dropped.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = FLUSH_DATA;
      skid_d  = FLUSH_DATA;
    end

    // The counter is not affected by flush. Only rst clears it.
    if (out_valid_q && !out_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // The registered handshake outputs are derived from the next state.
  assign out_valid_d = (state_d != ST_EMPTY);
  assign in_ready_d  = (state_d != ST_FULL);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= FLUSH_DATA;
      skid_q      <= FLUSH_DATA;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Scoreboard bench for pipe_stage_reg. The reference model is a FIFO of
//   accepted payloads with at most two entries, plus a stall count. A
//   stimulus-side process pushes each payload the model accepts. A monitor
//   pops on every output transfer and compares all outputs each cycle.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int unsigned      WIDTH   = 16;
  localparam logic [WIDTH-1:0] FLUSH_D = 16'h0013;
  localparam int unsigned      CNT_W   = 3;
  localparam int               CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  pipe_stage_reg #(
    .WIDTH(WIDTH),
    .FLUSH_DATA(FLUSH_D),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [WIDTH-1:0] held[$];        // accepted, not yet delivered, oldest first
  logic [WIDTH-1:0] last_data = FLUSH_D;
  int               mdl_cnt = 0;
  bit               mdl_in_ready = 1'b1;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // Stimulus side of the scoreboard: record each payload the model accepts.
  always @(posedge clk) begin
    if (!rst && !flush && in_valid && mdl_in_ready) held.push_back(in_data);
  end

  // Monitor: compare the outputs away from the edge, then advance the model
  // to account for what the coming edge does.
  initial begin
    int               sz;
    logic [WIDTH-1:0] exp_data;
    forever begin
      @(negedge clk);
      sz       = held.size();
      exp_data = (sz != 0) ? held[0] : last_data;
      check("out_valid", 64'(out_valid), 64'(sz != 0));
      check("in_ready",  64'(in_ready),  64'(sz < 2));
      check("occupancy", 64'(occupancy), 64'(sz));
      check("stall_cnt", 64'(stall_cnt), 64'(mdl_cnt));
      check("out_data",  64'(out_data),  64'(exp_data));
      mdl_in_ready = (sz < 2);
      if (rst) begin
        held.delete();
        last_data = FLUSH_D;
        mdl_cnt   = 0;
      end else begin
        if (sz != 0 && !out_ready && mdl_cnt < CNT_MAX) mdl_cnt++;
        if (sz != 0 && out_ready) last_data = held.pop_front();
        if (flush) begin
          held.delete();
          last_data = FLUSH_D;
        end
      end
    end
  end

  // Applies one cycle of inputs shortly after the rising edge.
  task automatic cyc(input bit r, input bit f, input bit iv,
                     input logic [WIDTH-1:0] d, input bit ordy);
    @(posedge clk);
    #1;
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, ordy);
  endtask

  initial begin
    // Reset for two edges
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);

    // Streaming 1..8 at full throughput
    for (int i = 1; i <= 8; i++) cyc(1'b0, 1'b0, 1'b1, WIDTH'(i), 1'b1);
    idle(2, 1'b1);

    // Back-pressure: A accepted, then B and C offered while stalled for 3 cycles
    cyc(1'b0, 1'b0, 1'b1, 16'h000A, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 16'h000B, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h000C, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h000C, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h000C, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 16'h000C, 1'b1);
    idle(3, 1'b1);

    // Flush in FULL while 0xD is offered
    cyc(1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0002, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h000D, 1'b0);
    idle(2, 1'b1);

    // Flush with a simultaneous drain from ONE
    cyc(1'b0, 1'b0, 1'b1, 16'h0005, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
    idle(2, 1'b1);

    // Saturation: hold one entry stalled, then flush
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0007, 1'b0);
    idle(CNT_MAX + 3, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    idle(2, 1'b0);

    // Reset mid-stall while FULL, then a 1-cycle-latency payload
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0021, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 16'h0022, 1'b0);
    idle(3, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 16'h0023, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 16'h0024, 1'b1);
    idle(2, 1'b1);

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 3) != 0), WIDTH'($urandom), ($urandom_range(0, 2) != 0));
    end
    idle(3, 1'b1);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
